// File: rtl/ltl_report_pkg.sv
// Shared defaults and entry type for the LTL report collector.
package ltl_report_pkg;

   localparam int NUM_REPORTS_DEF = 4;
   localparam int TS_WIDTH_DEF    = 16;
   localparam int FIFO_DEPTH_DEF  = 8;
   localparam int DROP_WIDTH_DEF  = 8;

   localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH_DEF) + 1;

   typedef struct packed {
      logic [NUM_REPORTS_DEF-1:0] report;
      logic [TS_WIDTH_DEF-1:0]    timestamp;
   } report_entry_t;

   // Occupancy needs one extra bit so full and empty are distinguishable.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ltl_report_fifo.sv
// Synchronous FIFO of report entries; head is read straight from the storage registers.
module ltl_report_fifo
   import ltl_report_pkg::*;
#(
   parameter type T     = report_entry_t,
   parameter int  DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  T                              push_data,
   input  logic                          pop,
   output T                              head,
   output logic                          empty,
   output logic                          full,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);

   T              mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full FIFO lands in the slot being vacated by the same-cycle pop.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/ltl_report_collector.sv
// Timestamps and buffers LTL cluster report cycles for the monitor host.
// Optional LTL_REPORT_DEDUP_EN: suppress repeats of an unchanged report vector.
module ltl_report_collector
   import ltl_report_pkg::*;
#(
   parameter int NUM_REPORTS = NUM_REPORTS_DEF,
   parameter int TS_WIDTH    = TS_WIDTH_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
   parameter int DROP_WIDTH  = DROP_WIDTH_DEF
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               run,
   input  logic                               ts_clear,
   input  logic [NUM_REPORTS-1:0]             report_in,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [NUM_REPORTS-1:0]             out_report,
   output logic [TS_WIDTH-1:0]                out_timestamp,
   output logic [level_width(FIFO_DEPTH)-1:0] fifo_level,
   output logic                               overflow,
   output logic [DROP_WIDTH-1:0]              drop_count,
   input  logic                               stat_clear
);

   typedef struct packed {
      logic [NUM_REPORTS-1:0] report;
      logic [TS_WIDTH-1:0]    timestamp;
   } entry_t;

   logic [TS_WIDTH-1:0] ts_q;
   logic                capture;
   logic                is_new;
   logic                pop;
   logic                full;
   logic                empty;
   logic                push;
   logic                drop;
   entry_t              push_data;
   entry_t              head;

`ifdef LTL_REPORT_DEDUP_EN
   logic [NUM_REPORTS-1:0] prev_report;

   // Tracks the last sampled vector even when its entry is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   prev_report <= '0;
      else if (run) prev_report <= report_in;
   end

   assign is_new = (report_in != prev_report);
`else
   assign is_new = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        ts_q <= '0;
      else if (ts_clear) ts_q <= '0;
      else if (run)      ts_q <= ts_q + TS_WIDTH'(1);
   end

   assign capture   = run && (report_in != '0) && is_new;
   assign pop       = out_valid && out_ready;
   assign push      = capture && (!full || pop);
   assign drop      = capture && full && !pop;
   assign push_data = '{report: report_in, timestamp: ts_q};

   ltl_report_fifo #(
      .T     (entry_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .empty     (empty),
      .full      (full),
      .level     (fifo_level)
   );

   assign out_valid     = !empty;
   assign out_report    = head.report;
   assign out_timestamp = head.timestamp;

   // A drop coinciding with stat_clear restarts the count at one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (stat_clear)             drop_count <= DROP_WIDTH'(1);
         else if (drop_count != '1)  drop_count <= drop_count + DROP_WIDTH'(1);
      end else if (stat_clear) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Scoreboard bench for ltl_report_collector: stimulus queues expected entries, a monitor pops on handshake.
module tb_ltl_report_collector;

   typedef struct packed {
      logic [3:0]  rep;
      logic [15:0] ts;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        run, ts_clear, out_ready, stat_clear;
   logic [3:0]  report_in;
   logic        out_valid;
   logic [3:0]  out_report;
   logic [15:0] out_timestamp;
   logic [3:0]  fifo_level;
   logic        overflow;
   logic [7:0]  drop_count;

   logic        b_run, b_ready;
   logic [3:0]  b_rep;
   logic        b_valid;
   logic [3:0]  b_out_report;
   logic [3:0]  b_out_ts;
   logic [3:0]  b_level;
   logic        b_overflow;
   logic [7:0]  b_drop;

   int          vecs = 0;
   int          errs = 0;
   exp_t        exp_q[$];
   logic [15:0] ts_model;

   always #5 clk = ~clk;

   ltl_report_collector dut (
      .clk(clk), .reset(reset), .run(run), .ts_clear(ts_clear), .report_in(report_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_report(out_report),
      .out_timestamp(out_timestamp), .fifo_level(fifo_level), .overflow(overflow),
      .drop_count(drop_count), .stat_clear(stat_clear)
   );

   ltl_report_collector #(.TS_WIDTH(4)) dut_b (
      .clk(clk), .reset(reset), .run(b_run), .ts_clear(1'b0), .report_in(b_rep),
      .out_valid(b_valid), .out_ready(b_ready), .out_report(b_out_report),
      .out_timestamp(b_out_ts), .fifo_level(b_level), .overflow(b_overflow),
      .drop_count(b_drop), .stat_clear(1'b0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus; exp_push marks cycles whose entry must be accepted.
   task automatic cyc(input logic r, input logic [3:0] rep, input logic rdy,
                      input logic sc, input logic exp_push);
      run = r; report_in = rep; out_ready = rdy; stat_clear = sc; ts_clear = 1'b0;
      if (exp_push) exp_q.push_back({rep, ts_model});
      @(posedge clk); #1;
      if (r) ts_model++;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      run = 0; ts_clear = 0; out_ready = 0; stat_clear = 0; report_in = '0;
      exp_q.delete();
      #10;
      reset = 1'b1;
      ts_model = '0;
   endtask

   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_entry", 32'(out_report), 32'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("entry_report", 32'(out_report), 32'(e.rep));
            check("entry_ts", 32'(out_timestamp), 32'(e.ts));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      run = 0; ts_clear = 0; out_ready = 0; stat_clear = 0; report_in = '0;
      b_run = 0; b_ready = 0; b_rep = '0;
      ts_model = '0;
      #22;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_report", 32'(out_report), 0);
      check("rst_ts", 32'(out_timestamp), 0);
      check("rst_level", 32'(fifo_level), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_drop", 32'(drop_count), 0);
      do_reset();

      // Idle reports: nothing captured, timestamp still advances.
      for (int i = 0; i < 10; i++) cyc(1, 4'b0000, 1, 0, 0);
      check("idle_valid", 32'(out_valid), 0);
      check("idle_ts", 32'(dut.ts_q), 10);
      run = 1; ts_clear = 1; @(posedge clk); #1; ts_clear = 0; ts_model = '0;
      check("ts_clear", 32'(dut.ts_q), 0);

      // Single report at ts=3 appears one cycle later.
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1, 4'b0000, 1, 0, 0);
      cyc(1, 4'b0100, 1, 0, 1);
      check("single_valid", 32'(out_valid), 1);
      check("single_report", 32'(out_report), 32'h4);
      check("single_ts", 32'(out_timestamp), 3);
      cyc(1, 4'b0000, 1, 0, 0);
      check("single_gone", 32'(out_valid), 0);

`ifndef LTL_REPORT_DEDUP_EN
      // Fill with host stalled: 8 accepted, 2 dropped.
      for (int i = 0; i < 10; i++) cyc(1, 4'b0001, 0, 0, i < 8);
      check("fill_level", 32'(fifo_level), 8);
      check("fill_overflow", 32'(overflow), 1);
      check("fill_drop", 32'(drop_count), 2);
      check("stall_head_ts", 32'(out_timestamp), 5);

      // Push into a full FIFO while popping is accepted.
      cyc(1, 4'b0010, 1, 0, 1);
      check("fullpp_level", 32'(fifo_level), 8);
      check("fullpp_drop", 32'(drop_count), 2);
      for (int i = 0; i < 10; i++) cyc(1, 4'b0000, 1, 0, 0);
      check("drain_level", 32'(fifo_level), 0);

      // Drop coinciding with stat_clear, then clear alone, then saturation.
      for (int i = 0; i < 8; i++) cyc(1, 4'b1000, 0, 0, 1);
      cyc(1, 4'b1000, 0, 1, 0);
      check("dropclr_overflow", 32'(overflow), 1);
      check("dropclr_drop", 32'(drop_count), 1);
      cyc(0, 4'b0000, 0, 1, 0);
      check("clr_overflow", 32'(overflow), 0);
      check("clr_drop", 32'(drop_count), 0);
      for (int i = 0; i < 300; i++) cyc(1, 4'b0001, 0, 0, 0);
      check("sat_drop", 32'(drop_count), 255);
      check("sat_overflow", 32'(overflow), 1);
      for (int i = 0; i < 10; i++) cyc(0, 4'b0001, 1, 0, 0);
      check("run0_drain_level", 32'(fifo_level), 0);
      check("run0_nocap_valid", 32'(out_valid), 0);
`else
      // Held report yields one entry; a changed vector yields another.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 4'b0011, 0, 0, i == 0);
      cyc(1, 4'b0010, 0, 0, 1);
      cyc(1, 4'b0000, 0, 0, 0);
      check("dedup_level", 32'(fifo_level), 2);
      for (int i = 0; i < 3; i++) cyc(1, 4'b0000, 1, 0, 0);
`endif

      // Reset in the middle of a drain discards everything at once.
      for (int i = 0; i < 5; i++) cyc(1, (i % 2) ? 4'b0010 : 4'b0001, 0, 0, 1);
      cyc(1, 4'b0000, 1, 0, 0);
      cyc(1, 4'b0000, 1, 0, 0);
      check("middrain_level", 32'(fifo_level), 3);
      reset = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 0);
      check("midrst_level", 32'(fifo_level), 0);
      exp_q.delete();
      #10;
      reset = 1'b1;
      ts_model = '0;

      // 4-bit timestamp wraps from 15 to 0.
      @(posedge clk); #1;
      for (int i = 0; i < 15; i++) begin
         b_run = 1; b_rep = 4'b0000; b_ready = 1;
         @(posedge clk); #1;
      end
      b_rep = 4'b0001;
      @(posedge clk); #1;
      check("wrap_valid", 32'(b_valid), 1);
      check("wrap_ts15", 32'(b_out_ts), 15);
      b_rep = 4'b0010;
      @(posedge clk); #1;
      check("wrap_ts0", 32'(b_out_ts), 0);
      check("wrap_report", 32'(b_out_report), 2);
      b_rep = 4'b0000; b_run = 0;
      @(posedge clk); #1;
      check("wrap_empty", 32'(b_valid), 0);

      check("queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
